tdoa_capture: RTL

Front end for the acoustic localizer. It watches four synchronous sensor hit lines and timestamps the first rising edge on each with a free-running capture counter. Once all four sensors have fired, it emits the three signed time differences of arrival (tau1..tau3, relative to sensor 0) in clock ticks, through a valid/ready handshake, in the 35-bit signed format the localizer core consumes. Incomplete captures are discarded after a programmable window.

---
 rtl/tdoa_capture_pkg.sv | 19 +
 rtl/tdoa_stamp.sv | 42 ++++
 rtl/tdoa_capture.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tdoa_capture_pkg.sv
// Shared definitions for the TDOA capture front end and the localizer core.
package tdoa_capture_pkg;

  localparam int unsigned TAU_W_DEF      = 35;
  localparam int unsigned CNT_W_DEF      = 34;
  localparam int unsigned MAX_WINDOW_DEF = 65535;
  localparam int unsigned NUM_SENSORS    = 4;

  // Fixed-point scale used by the localizer core (2^25).
  localparam longint unsigned FP_SCALE = 64'd1 << 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CALC  = 2'd2,
    ST_VALID = 2'd3
  } state_e;

endpackage

// File: rtl/tdoa_stamp.sv
// One sensor channel: rising-edge detect, captured flag and timestamp register.
module tdoa_stamp #(
  parameter int unsigned CNT_W = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hit_i,
  input  logic             clear_i,
  input  logic             cap_en_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             rise_c_o,
  output logic [CNT_W-1:0] ts_o,
  output logic             captured_o
);

  logic             hit_q;
  logic             cap_q;
  logic [CNT_W-1:0] ts_q;

  assign rise_c_o   = hit_i & ~hit_q;
  assign ts_o       = ts_q;
  assign captured_o = cap_q;

  // Only the first qualified rise per capture is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_q <= 1'b0;
      cap_q <= 1'b0;
      ts_q  <= '0;
    end else begin
      hit_q <= hit_i;
      if (clear_i) begin
        cap_q <= 1'b0;
        ts_q  <= '0;
      end else if (cap_en_i && rise_c_o && !cap_q) begin
        cap_q <= 1'b1;
        ts_q  <= cnt_i;
      end
    end
  end

endmodule

// File: rtl/tdoa_capture.sv
// Timestamps the first rise on each of four sensors and emits the three
// signed arrival-time differences against sensor 0 over valid/ready.
module tdoa_capture
  import tdoa_capture_pkg::*;
#(
  parameter int unsigned TAU_W      = TAU_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned MAX_WINDOW = MAX_WINDOW_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       hit_i,
  input  logic             tau_ready_i,
  output logic             tau_valid_o,
  output logic [TAU_W-1:0] tau1_o,
  output logic [TAU_W-1:0] tau2_o,
  output logic [TAU_W-1:0] tau3_o,
  output logic             timeout_o,
  output logic             busy_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             live_q;
  logic             tau_valid_q;
  logic             timeout_q;
  logic             busy_q;
  logic [TAU_W-1:0] tau1_q, tau2_q, tau3_q;

  logic [3:0]       rise_c;
  logic [3:0]       captured_c;
  logic [CNT_W-1:0] ts_c [NUM_SENSORS];
  logic [3:0]       mask_try_c;
  logic             arm_c, done_c, tmo_c, hs_c, cap_en_c, clear_c;
  logic [TAU_W-1:0] d1_c, d2_c, d3_c;

  // live_q masks the first edge after reset so lines already high stay silent.
  assign arm_c      = live_q && (state_q == ST_IDLE || state_q == ST_ARMED);
  assign mask_try_c = captured_c | (rise_c & {4{arm_c}});
  assign done_c     = (mask_try_c == 4'hF);
  assign tmo_c      = (state_q == ST_ARMED) && (cnt_q == CNT_W'(MAX_WINDOW)) && !done_c;
  assign hs_c       = (state_q == ST_VALID) && tau_valid_q && tau_ready_i;
  assign cap_en_c   = arm_c && !tmo_c;
  assign clear_c    = tmo_c || hs_c;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_stamp
    tdoa_stamp #(.CNT_W(CNT_W)) u_stamp (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .hit_i      (hit_i[g]),
      .clear_i    (clear_c),
      .cap_en_i   (cap_en_c),
      .cnt_i      (cnt_q),
      .rise_c_o   (rise_c[g]),
      .ts_o       (ts_c[g]),
      .captured_o (captured_c[g])
    );
  end

  // Zero-extended into TAU_W bits, so the difference cannot overflow.
  assign d1_c = TAU_W'(ts_c[1]) - TAU_W'(ts_c[0]);
  assign d2_c = TAU_W'(ts_c[2]) - TAU_W'(ts_c[0]);
  assign d3_c = TAU_W'(ts_c[3]) - TAU_W'(ts_c[0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      live_q      <= 1'b0;
      tau_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      tau1_q      <= '0;
      tau2_q      <= '0;
      tau3_q      <= '0;
    end else begin
      live_q    <= 1'b1;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|mask_try_c) begin
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= done_c ? ST_CALC : ST_ARMED;
          end
        end
        ST_ARMED: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (done_c) begin
            state_q <= ST_CALC;
          end else if (tmo_c) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_CALC: begin
          tau1_q      <= d1_c;
          tau2_q      <= d2_c;
          tau3_q      <= d3_c;
          tau_valid_q <= 1'b1;
          state_q     <= ST_VALID;
        end
        ST_VALID: begin
          if (hs_c) begin
            cnt_q       <= '0;
            tau_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign tau_valid_o = tau_valid_q;
  assign tau1_o      = tau1_q;
  assign tau2_o      = tau2_q;
  assign tau3_o      = tau3_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;

endmodule
